conbus1xn_ack: RTL and testbench

- Parametrised single-master to N-slave bus switch; next generation of the fixed 1x4 combinational switch.
- Adds a registered request/acknowledge handshake, variable per-slave wait states, a bus-timeout watchdog, and error return for unmapped regions.
- Sits between the CPU data port and the memory and peripheral slaves.
- Address decode uses the top SEL_BITS of the address.

---
 rtl/conbus_pkg.sv | 27 ++
 rtl/conbus1xn_ack_if.sv | 33 +++
 rtl/conbus_watchdog.sv | 36 +++
 rtl/conbus1xn_ack.sv | 142 ++++++++++++++
 tb/tb_conbus1xn_ack.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/conbus_pkg.sv
// rtl/conbus_pkg.sv - shared state encoding, default parameters and clog2 for the conbus switch
package conbus_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int DEF_DW       = 16;
  localparam int DEF_AW       = 16;
  localparam int DEF_NSLAVES  = 4;
  localparam int DEF_SEL_BITS = 2;
  localparam int DEF_TIMEOUT  = 255;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/conbus1xn_ack_if.sv
// rtl/conbus1xn_ack_if.sv - master-port and slave-port signal bundle of the 1xN switch
interface conbus1xn_ack_if
  import conbus_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int AW      = DEF_AW,
  parameter int NSLAVES = DEF_NSLAVES
);
  logic                    m_stb;
  logic                    m_we;
  logic [AW-1:0]           m_a;
  logic [DW-1:0]           m_do;
  logic [DW-1:0]           m_di;
  logic                    m_ack;
  logic                    m_err;
  logic [NSLAVES-1:0]      s_stb;
  logic [NSLAVES-1:0]      s_we;
  logic [AW-1:0]           s_a;
  logic [DW-1:0]           s_do;
  logic [NSLAVES*DW-1:0]   s_di;
  logic [NSLAVES-1:0]      s_ack;

  // slave: the switch itself; master: the CPU port together with the attached slave devices
  modport slave (
    input  m_stb, m_we, m_a, m_do, s_di, s_ack,
    output m_di, m_ack, m_err, s_stb, s_we, s_a, s_do
  );

  modport master (
    output m_stb, m_we, m_a, m_do, s_di, s_ack,
    input  m_di, m_ack, m_err, s_stb, s_we, s_a, s_do
  );
endinterface

// File: rtl/conbus_watchdog.sv
// rtl/conbus_watchdog.sv - saturating bus-access timeout counter; TIMEOUT=0 never expires
module conbus_watchdog
  import conbus_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = (TIMEOUT == 0) ? 1 : clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (TIMEOUT != 0) && (count_q == LAST);
endmodule

// File: rtl/conbus1xn_ack.sv
// rtl/conbus1xn_ack.sv - registered single-master to N-slave switch with ack, timeout and unmapped error
module conbus1xn_ack
  import conbus_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int AW       = DEF_AW,
  parameter int NSLAVES  = DEF_NSLAVES,
  parameter int SEL_BITS = DEF_SEL_BITS,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  conbus1xn_ack_if.slave    bus
);
  state_t               state_q, state_d;
  logic [SEL_BITS-1:0]  sel_q, sel_d;
  logic                 we_q, we_d;
  logic [NSLAVES-1:0]   s_stb_q, s_stb_d;
  logic [NSLAVES-1:0]   s_we_q, s_we_d;
  logic [AW-1:0]        s_a_q, s_a_d;
  logic [DW-1:0]        s_do_q, s_do_d;
  logic [DW-1:0]        m_di_q, m_di_d;
  logic                 m_ack_q, m_ack_d;
  logic                 m_err_q, m_err_d;

  logic [SEL_BITS-1:0]  req_sel;
  logic [NSLAVES-1:0]   req_hit;
  logic                 sel_ack;
  logic [DW-1:0]        sel_di;
  logic                 wd_clr, wd_en, wd_expire;

  conbus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    we_d    = we_q;
    s_stb_d = s_stb_q;
    s_we_d  = s_we_q;
    s_a_d   = s_a_q;
    s_do_d  = s_do_q;
    m_di_d  = m_di_q;
    m_ack_d = 1'b0;
    m_err_d = 1'b0;
    wd_clr  = 1'b0;
    wd_en   = 1'b0;
    sel_ack = 1'b0;
    sel_di  = '0;
    req_sel = bus.m_a[AW-1 -: SEL_BITS];
    req_hit = '0;

    // An empty req_hit means the select value has no slave behind it
    for (int k = 0; k < NSLAVES; k++) begin
      req_hit[k] = (req_sel == SEL_BITS'(k));
      if (sel_q == SEL_BITS'(k)) begin
        sel_ack = bus.s_ack[k];
        sel_di  = bus.s_di[k*DW +: DW];
      end
    end

    case (state_q)
      IDLE: begin
        // The ack/err guard keeps a request still held in its completion cycle from restarting
        if (bus.m_stb && !m_ack_q && !m_err_q) begin
          sel_d  = req_sel;
          s_a_d  = bus.m_a;
          s_do_d = bus.m_do;
          we_d   = bus.m_we;
          wd_clr = 1'b1;
          if (|req_hit) begin
            s_stb_d = req_hit;
            s_we_d  = bus.m_we ? req_hit : '0;
            state_d = ACCESS;
          end else begin
            m_err_d = 1'b1;
            m_di_d  = '0;
          end
        end
      end
      ACCESS: begin
        if (sel_ack) begin
          m_ack_d = 1'b1;
          if (!we_q) begin
            m_di_d = sel_di;
          end
          s_stb_d = '0;
          s_we_d  = '0;
          state_d = IDLE;
        end else if (wd_expire) begin
          m_err_d = 1'b1;
          m_di_d  = '0;
          s_stb_d = '0;
          s_we_d  = '0;
          state_d = IDLE;
        end else begin
          wd_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      we_q    <= 1'b0;
      s_stb_q <= '0;
      s_we_q  <= '0;
      s_a_q   <= '0;
      s_do_q  <= '0;
      m_di_q  <= '0;
      m_ack_q <= 1'b0;
      m_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      s_stb_q <= s_stb_d;
      s_we_q  <= s_we_d;
      s_a_q   <= s_a_d;
      s_do_q  <= s_do_d;
      m_di_q  <= m_di_d;
      m_ack_q <= m_ack_d;
      m_err_q <= m_err_d;
    end
  end

  assign bus.s_stb = s_stb_q;
  assign bus.s_we  = s_we_q;
  assign bus.s_a   = s_a_q;
  assign bus.s_do  = s_do_q;
  assign bus.m_di  = m_di_q;
  assign bus.m_ack = m_ack_q;
  assign bus.m_err = m_err_q;
endmodule

// File: tb/tb_conbus1xn_ack.sv
// tb/tb_conbus1xn_ack.sv - randomized self-checking bench for conbus1xn_ack
module tb_conbus1xn_ack;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int NS = 3;
  localparam int SB = 2;
  localparam int TO = 8;
  localparam int NEVER = 255;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  conbus1xn_ack_if #(.DW(DW), .AW(AW), .NSLAVES(NS)) bus ();

  conbus1xn_ack #(.DW(DW), .AW(AW), .NSLAVES(NS), .SEL_BITS(SB), .TIMEOUT(TO)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  int            checks = 0;
  int            errors = 0;
  int            wait_cfg [NS];
  int            stb_cnt [NS];
  logic [DW-1:0] sdi [NS];
  logic [NS-1:0] force_ack = '0;
  logic [NS-1:0] ack_vec;
  logic [DW-1:0] exp_mdi = '0;

  // Slave k acks once its strobe has been high for wait_cfg[k] earlier cycles
  always @(posedge sys_clk) begin
    for (int k = 0; k < NS; k++) begin
      stb_cnt[k] <= bus.s_stb[k] ? stb_cnt[k] + 1 : 0;
    end
  end

  always_comb begin
    ack_vec = force_ack;
    for (int k = 0; k < NS; k++) begin
      if (bus.s_stb[k] && (stb_cnt[k] == wait_cfg[k])) ack_vec[k] = 1'b1;
    end
  end

  assign bus.s_ack = ack_vec;
  assign bus.s_di  = {sdi[2], sdi[1], sdi[0]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_stb"}, 32'(bus.s_stb), 0);
    chk({tag, "_we"}, 32'(bus.s_we), 0);
    chk({tag, "_sa"}, 32'(bus.s_a), 0);
    chk({tag, "_sdo"}, 32'(bus.s_do), 0);
    chk({tag, "_mdi"}, 32'(bus.m_di), 0);
    chk({tag, "_ackerr"}, {30'd0, bus.m_ack, bus.m_err}, 0);
  endtask

  // One master transfer; expectations come from the timing rules, not the DUT
  task automatic xfer(input string tag, input logic [AW-1:0] addr, input logic we,
                      input logic [DW-1:0] wd, input logic [DW-1:0] rd, input int wt);
    logic [SB-1:0] sel;
    int            si;
    bit            mapped;
    int            exp_lat;
    bit            exp_ack;
    logic [NS-1:0] onehot;
    int            lat;
    int            stbc;
    bit            done;
    sel    = addr[AW-1 -: SB];
    si     = int'(sel);
    mapped = (si < NS);
    onehot = mapped ? NS'(1) << si : '0;
    if (mapped) begin
      wait_cfg[si] = wt;
      sdi[si]      = rd;
    end
    exp_ack = mapped && (wt <= TO - 1);
    exp_lat = !mapped ? 1 : (exp_ack ? wt + 1 : TO);

    @(negedge sys_clk);
    bus.m_stb = 1'b1;
    bus.m_we  = we;
    bus.m_a   = addr;
    bus.m_do  = wd;
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk({tag, "_sstb"}, 32'(bus.s_stb), 32'(onehot));
    chk({tag, "_swe"}, 32'(bus.s_we), 32'(we ? onehot : '0));
    if (mapped) begin
      chk({tag, "_sa"}, 32'(bus.s_a), 32'(addr));
      chk({tag, "_sdo"}, 32'(bus.s_do), 32'(wd));
    end
    bus.m_a  = AW'($urandom);
    bus.m_do = DW'($urandom);
    bus.m_we = 1'($urandom);

    lat  = 0;
    stbc = 0;
    done = (bus.m_ack || bus.m_err);
    lat  = done ? 1 : 0;
    while (!done && lat < 40) begin
      if (bus.s_stb != 0) stbc++;
      @(posedge sys_clk);
      lat++;
      @(negedge sys_clk);
      if (bus.m_ack || bus.m_err) done = 1'b1;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_acks"}, {30'd0, bus.m_ack, bus.m_err}, {30'd0, exp_ack, !exp_ack});
    if (mapped) chk({tag, "_stbcyc"}, 32'(stbc), 32'(exp_lat));
    if (!exp_ack) exp_mdi = '0;
    else if (!we) exp_mdi = rd;
    chk({tag, "_mdi"}, 32'(bus.m_di), 32'(exp_mdi));
    bus.m_stb = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk({tag, "_pulse"}, {30'd0, bus.m_ack, bus.m_err}, 0);
  endtask

  initial begin
    int spur;
    int sel_r;
    int wts [7] = '{0, 1, 2, 3, 7, 8, NEVER};
    bus.m_stb = 1'b0;
    bus.m_we  = 1'b0;
    bus.m_a   = '0;
    bus.m_do  = '0;
    for (int k = 0; k < NS; k++) begin
      wait_cfg[k] = NEVER;
      sdi[k]      = '0;
    end
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk_idle_outputs("rst0");
    sys_rst = 1'b0;

    // Reset in the middle of an access that never completes
    wait_cfg[1] = NEVER;
    bus.m_stb = 1'b1;
    bus.m_a   = 16'h4000;
    bus.m_we  = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk_idle_outputs("rstmid");
    sys_rst   = 1'b0;
    bus.m_stb = 1'b0;
    spur = 0;
    repeat (12) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (bus.m_ack || bus.m_err) spur++;
    end
    chk("rst_noack", 32'(spur), 0);
    exp_mdi = '0;
    xfer("after_rst", 16'h4000, 1'b0, 16'h0, 16'h5A5A, 1);

    xfer("zw_read", 16'h8012, 1'b0, 16'h0, 16'hBEEF, 0);
    xfer("ws_write", 16'h0004, 1'b1, 16'h1234, 16'hDEAD, 3);
    xfer("timeout", 16'h8000, 1'b0, 16'h0, 16'h1111, NEVER);
    xfer("unmapped", 16'hC010, 1'b0, 16'h0, 16'h0, 0);
    force_ack = 3'b100;
    xfer("spurious", 16'h4000, 1'b0, 16'h0, 16'h7777, 3);
    xfer("ack_vs_to", 16'h4000, 1'b0, 16'h0, 16'h2468, TO - 1);
    force_ack = '0;

    for (int n = 0; n < 30; n++) begin
      logic [AW-1:0] a;
      a     = AW'($urandom);
      sel_r = int'(a[AW-1 -: SB]);
      force_ack = NS'($urandom) & ~((sel_r < NS) ? NS'(1) << sel_r : NS'(0));
      xfer("rand", a, 1'($urandom), DW'($urandom), DW'($urandom), wts[$urandom_range(0, 6)]);
    end
    force_ack = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
